wb_rr_arbiter: RTL

//  Round-robin Wishbone B3 arbiter sharing one slave port (e.g. wb_ram0) between N masters
//  (or1k_i, or1k_d, dbg). Grants one master per bus cycle and holds the grant for the whole

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_arb_rr_pick.sv | 36 +++
 rtl/wb_rr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM state
// encoding, Wishbone cycle-type constants and an index-width helper.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END       = 3'b111;

    // Bits needed to hold an index in 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: starting one position after the last
// owner and wrapping, the first asserted request wins.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int IW          = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last_idx,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IW-1:0]          gnt_idx,
    output logic                   valid
);

    int idx_s;

    // Walk the masters in rotating order and keep the first requester found.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        idx_s   = 0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            idx_s = (int'(last_idx) + off) % NUM_MASTERS;
            if (req[idx_s] && !valid) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = IW'(idx_s);
                valid      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: N masters share one slave port. A grant
// is held for the whole CYC period (bursts included); the slave response is
// routed to the granted master only.
// Optional bus watchdog: define WB_ARB_TIMEOUT_EN to abort a cycle with an
// error after TIMEOUT_CYCLES strobed cycles without any slave response.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = clog2(NUM_MASTERS);

    arb_state_e             state_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [IW-1:0]          gnt_idx_r;
    logic [IW-1:0]          last_idx_r;

    logic [NUM_MASTERS-1:0] pick_gnt_s;
    logic [IW-1:0]          pick_idx_s;
    logic                   pick_valid_s;

    logic busy_s;
    logic cyc_sel_s;
    logic stb_sel_s;
    logic fwd_s;
    logic timeout_hit_s;

    wb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_pick (
        .req      (wbm_cyc_i),
        .last_idx (last_idx_r),
        .gnt      (pick_gnt_s),
        .gnt_idx  (pick_idx_s),
        .valid    (pick_valid_s)
    );

    assign busy_s = (state_r == ST_BUSY);

    // AND-OR mux of the granted master onto the slave side; all zero when no grant.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = 3'b000;
        wbs_bte_o = 2'b00;
        cyc_sel_s = 1'b0;
        stb_sel_s = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            wbs_adr_o = wbs_adr_o | (wbm_adr_i[k*AW +: AW] & {AW{grant_r[k]}});
            wbs_dat_o = wbs_dat_o | (wbm_dat_i[k*DW +: DW] & {DW{grant_r[k]}});
            wbs_sel_o = wbs_sel_o | (wbm_sel_i[k*SW +: SW] & {SW{grant_r[k]}});
            wbs_we_o  = wbs_we_o  | (wbm_we_i[k] & grant_r[k]);
            wbs_cti_o = wbs_cti_o | (wbm_cti_i[k*3 +: 3] & {3{grant_r[k]}});
            wbs_bte_o = wbs_bte_o | (wbm_bte_i[k*2 +: 2] & {2{grant_r[k]}});
            cyc_sel_s = cyc_sel_s | (wbm_cyc_i[k] & grant_r[k]);
            stb_sel_s = stb_sel_s | (wbm_stb_i[k] & grant_r[k]);
        end
    end

    // Slave CYC/STB follow the owner combinationally so a release is seen the same cycle.
    assign wbs_cyc_o = busy_s & cyc_sel_s & ~timeout_hit_s;
    assign wbs_stb_o = wbs_cyc_o & stb_sel_s;

    // Responses are forwarded only while the owner's cycle is live on the slave.
    assign fwd_s     = wbs_cyc_o;
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = grant_r & {NUM_MASTERS{wbs_ack_i & fwd_s}};
    assign wbm_err_o = grant_r & {NUM_MASTERS{(wbs_err_i & fwd_s) | timeout_hit_s}};
    assign wbm_rty_o = grant_r & {NUM_MASTERS{wbs_rty_i & fwd_s}};
    assign grant_o   = grant_r;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int            CW       = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] to_cnt_r;
    logic          resp_s;

    assign resp_s        = busy_s & cyc_sel_s & (wbs_ack_i | wbs_err_i | wbs_rty_i);
    assign timeout_hit_s = busy_s & (to_cnt_r == TO_LIMIT);

    // Watchdog: counts strobed cycles without a response while an owner holds the bus.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt_r <= '0;
        end else if (!busy_s || timeout_hit_s || resp_s) begin
            to_cnt_r <= '0;
        end else if (cyc_sel_s && stb_sel_s) begin
            to_cnt_r <= to_cnt_r + CW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Arbitration FSM: pick in IDLE, hold the grant in BUSY until CYC drops (or the watchdog fires).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gnt_idx_r  <= '0;
            last_idx_r <= IW'(NUM_MASTERS - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_r   <= ST_BUSY;
                        grant_r   <= pick_gnt_s;
                        gnt_idx_r <= pick_idx_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        grant_r   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!cyc_sel_s || timeout_hit_s) begin
                        state_r    <= ST_IDLE;
                        grant_r    <= '0;
                        last_idx_r <= gnt_idx_r;
                    end else begin
                        state_r    <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule
